// File: rtl/rat_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rat_pkg
//  Desc     : Shared types and constants for the interrupt controller:
//             controller state encoding, interrupt vector for the PC mux,
//             and synchronizer depth.
//  Revision : 1.0 - initial release
// ============================================================================
package rat_pkg;

  // Interrupt controller sequencing states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PENDING = 3'd1,
    ENTRY   = 3'd2,
    ISR     = 3'd3,
    EXIT    = 3'd4
  } intr_state_t;

  // Service routine entry address, selected by the PC mux on interrupt entry
  localparam logic [9:0] INTR_VECTOR = 10'h3FF;

  // Depth of the INTR metastability synchronizer (INTR_SYNC_EN builds only)
  localparam int NUM_SYNC_STAGES = 2;

endpackage
`default_nettype wire

// File: rtl/edge_sync.sv
`default_nettype none
// ============================================================================
//  Module   : edge_sync
//  Desc     : Optional INTR synchronizer followed by rising-edge detection.
//             EDGE_PULSE is a one-cycle pulse per qualified rising edge.
//             Build option: INTR_SYNC_EN inserts a NUM_SYNC_STAGES-deep
//             synchronizer; without it INTR must already be CLK-synchronous.
//  Revision : 1.0 - initial release
// ============================================================================
module edge_sync
  import rat_pkg::*;
(
  input  logic CLK,
  input  logic RESET_N,
  input  logic INTR,
  output logic EDGE_PULSE
);

  logic sample;      // INTR as seen by the edge detector
  logic sample_vld;  // sample reflects the real INTR level (post-reset fill)
  logic prev_q, prev_d;
  logic armed_q, armed_d;

`ifdef INTR_SYNC_EN
  logic [NUM_SYNC_STAGES-1:0] sync_q, sync_d;
  logic [NUM_SYNC_STAGES-1:0] vld_q, vld_d;

  // Shift INTR through the synchronizer alongside a validity marker
  always_comb begin
    sync_d = {sync_q[NUM_SYNC_STAGES-2:0], INTR};
    vld_d  = {vld_q[NUM_SYNC_STAGES-2:0], 1'b1};
  end

  // Synchronizer registers
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      sync_q <= '0;
      vld_q  <= '0;
    end else begin
      sync_q <= sync_d;
      vld_q  <= vld_d;
    end
  end

  assign sample     = sync_q[NUM_SYNC_STAGES-1];
  assign sample_vld = vld_q[NUM_SYNC_STAGES-1];
`else
  assign sample     = INTR;
  assign sample_vld = 1'b1;
`endif

  // Edge detect state; detection is armed only after a genuine low level has
  // been seen, so an INTR held high across reset release is not an edge
  always_comb begin
    prev_d  = sample;
    armed_d = armed_q | (sample_vld & ~sample);
  end

  // Edge detect registers
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      armed_q <= armed_d;
    end
  end

  assign EDGE_PULSE = sample & ~prev_q & armed_q;

endmodule
`default_nettype wire

// File: rtl/intr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : intr_ctrl
//  Desc     : Single-level interrupt controller. Latches one pending request,
//             handshakes with the control unit (INT_REQ / INT_ACK), sequences
//             flag save on entry and flag restore on RETIE, owns I_FLAG.
//             Build option: INTR_SYNC_EN enables the INTR synchronizer.
//  Revision : 1.0 - initial release
// ============================================================================
module intr_ctrl
  import rat_pkg::*;
(
  input  logic CLK,
  input  logic RESET_N,
  input  logic INTR,
  input  logic I_SET,
  input  logic I_CLR,
  input  logic INT_ACK,
  input  logic RETIE,
  output logic INT_REQ,
  output logic I_FLAG,
  output logic FLG_SHAD_LD,
  output logic FLG_LD_SEL,
  output logic FLG_RESTORE,
  output logic IN_ISR
);

  intr_state_t state_q, state_d;
  logic        pend_q, pend_d;
  logic        i_flag_q, i_flag_d;
  logic        edge_pulse;
  logic        ack_take;
  logic        pend_seen;

  edge_sync u_edge_sync (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .INTR       (INTR),
    .EDGE_PULSE (edge_pulse)
  );

  // Next state, pend latch and interrupt-enable flag
  always_comb begin
    state_d   = state_q;
    ack_take  = INT_ACK && (state_q == PENDING) && i_flag_q;
    // An edge arriving this cycle counts as pending for transition decisions
    pend_seen = pend_q | edge_pulse;
    pend_d    = (pend_q & ~ack_take) | edge_pulse;

    case (state_q)
      IDLE: begin
        if (RETIE)          state_d = EXIT;
        else if (pend_seen) state_d = PENDING;
      end
      PENDING: begin
        if (ack_take)       state_d = ENTRY;
        else if (RETIE)     state_d = EXIT;
      end
      ENTRY:                state_d = ISR;
      ISR: begin
        if (RETIE)          state_d = EXIT;
      end
      EXIT:                 state_d = pend_seen ? PENDING : IDLE;
      default:              state_d = IDLE;
    endcase

    // I_FLAG is already cleared during ENTRY and set during EXIT
    if (state_d == ENTRY)     i_flag_d = 1'b0;
    else if (state_d == EXIT) i_flag_d = 1'b1;
    else if (I_CLR)           i_flag_d = 1'b0;
    else if (I_SET)           i_flag_d = 1'b1;
    else                      i_flag_d = i_flag_q;
  end

  // Controller registers
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      pend_q   <= 1'b0;
      i_flag_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      i_flag_q <= i_flag_d;
    end
  end

  assign INT_REQ     = (state_q == PENDING) && i_flag_q;
  assign I_FLAG      = i_flag_q;
  assign FLG_SHAD_LD = (state_q == ENTRY);
  assign FLG_LD_SEL  = (state_q == EXIT);
  assign FLG_RESTORE = (state_q == EXIT);
  assign IN_ISR      = (state_q == ISR);

endmodule
`default_nettype wire
